mem_burst_arb: RTL and testbench

- Two-requester round-robin arbiter that shares one main-memory burst port between two line-fill/write-back engines, e.g. two cache_fa_lru-style controllers or a cache plus a DMA.
- Grants whole line bursts, never single beats: a line is BEATS beats of BEAT_BITS each.
- Sits between the requesters' mem_* interfaces and the memory model.
- Guarantees mem_req is low for at least two cycles between bursts, so burst boundaries are observable on the bus.

---
 rtl/mem_burst_arb.sv | 214 +++++++++++++++++++++
 tb/tb_mem_burst_arb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_arb.sv
// -----------------------------------------------------------------------------
// mem_burst_arb
//
// Purpose:
//    Two-requester round-robin arbiter that shares one main-memory burst port
//    between two line-fill / write-back engines. Arbitration is per whole line
//    burst of BEATS beats, never per beat. After each burst the bus is held
//    idle (mem_req low) for two cycles so burst boundaries stay visible.
//
//    State flow: IDLE -> BUSY -> GAP -> IDLE
//       IDLE : sample p0_req/p1_req, pick an owner (round robin on conflict)
//       BUSY : route the owner's request to memory, count beats
//       GAP  : one cycle with burst_done high, bus idle
//
// Ports:
//    clk, rst          rising-edge clock, synchronous active-high reset
//    p0_* / p1_*       requester burst interfaces
//                         req    (in)  held high until its last beat completes
//                         wr     (in)  1 = write-back, 0 = line fill
//                         addr   (in)  line-aligned burst address
//                         wdata  (in)  current write beat
//                         ready  (out) write beat accepted (owner only)
//                         rvalid (out) read beat valid (owner only)
//    rdata             (out) mem_rdata broadcast to both requesters
//    mem_req           (out) burst active to memory
//    mem_wr            (out) burst direction
//    mem_addr          (out) burst address
//    mem_wdata         (out) write beat
//    mem_ready         (in)  memory accepted a write beat
//    mem_rvalid        (in)  memory returns a read beat
//    mem_rdata         (in)  read beat data
//    gnt               (out) one-hot current owner, 00 when idle
//    burst_done        (out) one-cycle pulse on the cycle after the last beat
// -----------------------------------------------------------------------------
module mem_burst_arb #(
   parameter int ADDR_BITS = 16,
   parameter int BEAT_BITS = 64,
   parameter int BEATS     = 8,
   parameter int CNT_BITS  = 3
) (
   input  logic                 clk,
   input  logic                 rst,

   input  logic                 p0_req,
   input  logic                 p0_wr,
   input  logic [ADDR_BITS-1:0] p0_addr,
   input  logic [BEAT_BITS-1:0] p0_wdata,
   output logic                 p0_ready,
   output logic                 p0_rvalid,

   input  logic                 p1_req,
   input  logic                 p1_wr,
   input  logic [ADDR_BITS-1:0] p1_addr,
   input  logic [BEAT_BITS-1:0] p1_wdata,
   output logic                 p1_ready,
   output logic                 p1_rvalid,

   output logic [BEAT_BITS-1:0] rdata,

   output logic                 mem_req,
   output logic                 mem_wr,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [BEAT_BITS-1:0] mem_wdata,
   input  logic                 mem_ready,
   input  logic                 mem_rvalid,
   input  logic [BEAT_BITS-1:0] mem_rdata,

   output logic [1:0]           gnt,
   output logic                 burst_done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

   // Registered state
   state_t              r_state;
   logic                r_owner;        // 0 = port 0, 1 = port 1 (valid in BUSY)
   logic                r_last_owner;   // owner of the most recent finished burst
   logic [CNT_BITS-1:0] r_beat_cnt;

   // Next-state values
   state_t              w_state_nxt;
   logic                w_owner_nxt;
   logic                w_last_owner_nxt;
   logic [CNT_BITS-1:0] w_beat_cnt_nxt;

   // Decode helpers
   logic                w_busy;
   logic                w_own_wr;
   logic                w_strobe;
   logic                w_pick;

   assign w_busy   = (r_state == ST_BUSY);
   assign w_own_wr = r_owner ? p1_wr : p0_wr;

   // Only the strobe matching the burst direction counts as a beat; a stray
   // strobe of the other type is dropped here and never reaches a requester.
   assign w_strobe = w_busy & (w_own_wr ? mem_ready : mem_rvalid);

   // On conflict the port that did not own the previous burst wins; with a
   // single request that port wins regardless of history.
   assign w_pick = (p0_req & p1_req) ? ~r_last_owner : p1_req;

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_owner      <= 1'b0;
         r_last_owner <= 1'b1;          // port 0 wins the first conflict
         r_beat_cnt   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_last_owner <= w_last_owner_nxt;
         r_beat_cnt   <= w_beat_cnt_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   // NOTE: every variable gets a default at the top of the block, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt      = r_state;
      w_owner_nxt      = r_owner;
      w_last_owner_nxt = r_last_owner;
      w_beat_cnt_nxt   = r_beat_cnt;

      unique case (r_state)
         ST_IDLE: begin
            if (p0_req | p1_req) begin
               w_state_nxt    = ST_BUSY;
               w_owner_nxt    = w_pick;
               w_beat_cnt_nxt = '0;
            end
         end

         ST_BUSY: begin
            // Requests are not looked at here: once granted, a burst always
            // runs its full BEATS beats even if the owner drops req.
            if (w_strobe) begin
               if (r_beat_cnt == LAST_BEAT) begin
                  w_state_nxt      = ST_GAP;
                  w_last_owner_nxt = r_owner;
                  w_beat_cnt_nxt   = '0;
               end else begin
                  w_beat_cnt_nxt = r_beat_cnt + 1'b1;
               end
            end
         end

         ST_GAP: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Output logic
   // --------------------------------------------------------------------------
   // The whole memory-side bus is forced to zero outside BUSY, so GAP and IDLE
   // together give the two idle cycles between consecutive bursts.
   always_comb begin
      gnt       = 2'b00;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      p0_ready  = 1'b0;
      p0_rvalid = 1'b0;
      p1_ready  = 1'b0;
      p1_rvalid = 1'b0;

      if (w_busy) begin
         mem_req = 1'b1;
         mem_wr  = w_own_wr;
         if (r_owner) begin
            gnt       = 2'b10;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            p1_ready  = w_own_wr & mem_ready;
            p1_rvalid = ~w_own_wr & mem_rvalid;
         end else begin
            gnt       = 2'b01;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            p0_ready  = w_own_wr & mem_ready;
            p0_rvalid = ~w_own_wr & mem_rvalid;
         end
      end
   end

   // GAP is entered only from the last beat and lasts exactly one cycle,
   // which is precisely the burst_done pulse.
   assign burst_done = (r_state == ST_GAP);

   // Read data is a plain broadcast; requesters qualify it with p*_rvalid.
   assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_burst_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_burst_arb
//
// Purpose:
//    Directed self-checking bench for mem_burst_arb. Inputs are driven 1 ns
//    after the rising edge and outputs are sampled 2 ns after it. The bench
//    plays the memory directly, choosing on which cycles strobes appear.
// -----------------------------------------------------------------------------
module tb_mem_burst_arb;

   localparam int ADDR_BITS = 16;
   localparam int BEAT_BITS = 64;
   localparam int BEATS     = 8;
   localparam int CNT_BITS  = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 p0_req, p0_wr, p1_req, p1_wr;
   logic [ADDR_BITS-1:0] p0_addr, p1_addr;
   logic [BEAT_BITS-1:0] p0_wdata, p1_wdata;
   logic                 p0_ready, p0_rvalid, p1_ready, p1_rvalid;
   logic [BEAT_BITS-1:0] rdata;
   logic                 mem_req, mem_wr;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [BEAT_BITS-1:0] mem_wdata;
   logic                 mem_ready, mem_rvalid;
   logic [BEAT_BITS-1:0] mem_rdata;
   logic [1:0]           gnt;
   logic                 burst_done;

   int n_pass      = 0;
   int n_total     = 0;
   int total_beats = 0;

   always #5 clk = ~clk;

   mem_burst_arb #(
      .ADDR_BITS (ADDR_BITS),
      .BEAT_BITS (BEAT_BITS),
      .BEATS     (BEATS),
      .CNT_BITS  (CNT_BITS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .p0_req     (p0_req),
      .p0_wr      (p0_wr),
      .p0_addr    (p0_addr),
      .p0_wdata   (p0_wdata),
      .p0_ready   (p0_ready),
      .p0_rvalid  (p0_rvalid),
      .p1_req     (p1_req),
      .p1_wr      (p1_wr),
      .p1_addr    (p1_addr),
      .p1_wdata   (p1_wdata),
      .p1_ready   (p1_ready),
      .p1_rvalid  (p1_rvalid),
      .rdata      (rdata),
      .mem_req    (mem_req),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .gnt        (gnt),
      .burst_done (burst_done)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Two reset edges, check the idle bus, release reset. Returns in IDLE.
   task automatic do_reset();
      rst        = 1'b1;
      p0_req     = 1'b0;  p0_wr = 1'b0;  p0_addr = '0;  p0_wdata = '0;
      p1_req     = 1'b0;  p1_wr = 1'b0;  p1_addr = '0;  p1_wdata = '0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      cyc();
      cyc();
      #1;
      check("rst_gnt",   gnt, 2'b00);
      check("rst_req",   mem_req, 1'b0);
      check("rst_done",  burst_done, 1'b0);
      check("rst_addr",  mem_addr, '0);
      check("rst_wr",    mem_wr, 1'b0);
      check("rst_wdata", mem_wdata, '0);
      check("rst_strb",  {p0_ready, p0_rvalid, p1_ready, p1_rvalid}, 4'b0000);
      rst = 1'b0;
   endtask

   // Called on the first BUSY cycle. Runs n beats; with stall set, strobes
   // appear only on odd cycles, and with junk set the even cycles carry a
   // strobe of the wrong type. Returns 1 ns after the edge of the last beat.
   task automatic do_burst(input bit port, input bit wr, input bit stall, input bit junk,
                           input logic [15:0] addr, input int n);
      int beats = 0;
      int cyc_n = 0;
      int seen  = 0;
      bit strobe;
      while (beats < n && cyc_n < 40) begin
         strobe     = !(stall && (cyc_n % 2 == 0));
         p0_wdata   = 64'hA0A0_0000_0000_0000 | 64'(cyc_n);
         p1_wdata   = 64'hB1B1_0000_0000_0000 | 64'(cyc_n);
         mem_rdata  = {$urandom(), $urandom()};
         mem_ready  = wr ? strobe : (junk & !strobe);
         mem_rvalid = wr ? (junk & !strobe) : strobe;
         #1;
         check("busy_req",   mem_req, 1'b1);
         check("busy_gnt",   gnt, port ? 2'b10 : 2'b01);
         check("busy_addr",  mem_addr, addr);
         check("busy_wr",    mem_wr, wr);
         check("busy_wdata", mem_wdata, port ? p1_wdata : p0_wdata);
         check("owner_strb", port ? {p1_ready, p1_rvalid} : {p0_ready, p0_rvalid},
               {wr & strobe, !wr & strobe});
         check("other_strb", port ? {p0_ready, p0_rvalid} : {p1_ready, p1_rvalid}, 2'b00);
         check("rdata",      rdata, mem_rdata);
         check("busy_done",  burst_done, 1'b0);
         if (strobe) beats++;
         if (port ? (p1_ready | p1_rvalid) : (p0_ready | p0_rvalid)) begin
            seen++;
            total_beats++;
         end
         cyc_n++;
         cyc();
      end
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      check("burst_cycles", 64'(cyc_n), stall ? 64'(2 * n) : 64'(n));
      check("burst_beats",  64'(seen), 64'(n));
   endtask

   // Called on the GAP cycle; checks GAP and the following IDLE cycle.
   task automatic gap_checks();
      #1;
      check("gap_req",  mem_req, 1'b0);
      check("gap_gnt",  gnt, 2'b00);
      check("gap_done", burst_done, 1'b1);
      check("gap_addr", mem_addr, '0);
      cyc();
      #1;
      check("idle_req",  mem_req, 1'b0);
      check("idle_gnt",  gnt, 2'b00);
      check("idle_done", burst_done, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // ---------------- single fill on port 0 ----------------
      do_reset();
      p0_req  = 1'b1;
      p0_wr   = 1'b0;
      p0_addr = 16'h0040;
      #1;
      check("t1_pre_req", mem_req, 1'b0);
      cyc();
      #1;
      check("t1_gnt",  gnt, 2'b01);
      check("t1_req",  mem_req, 1'b1);
      check("t1_addr", mem_addr, 16'h0040);
      do_burst(1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 8);
      p0_req = 1'b0;
      gap_checks();
      cyc();
      #1;
      check("t1_stay_idle", mem_req, 1'b0);

      // ------- simultaneous request, then stalled write-back on port 1 -------
      do_reset();
      p0_req  = 1'b1;  p0_wr = 1'b0;  p0_addr = 16'h0080;
      p1_req  = 1'b1;  p1_wr = 1'b1;  p1_addr = 16'h01C0;
      cyc();
      #1;
      check("t2_first_gnt",  gnt, 2'b01);
      check("t2_first_addr", mem_addr, 16'h0080);
      do_burst(1'b0, 1'b0, 1'b0, 1'b0, 16'h0080, 8);
      p0_req = 1'b0;
      gap_checks();
      cyc();
      #1;
      check("t2_second_gnt",  gnt, 2'b10);
      check("t2_second_req",  mem_req, 1'b1);
      check("t2_second_addr", mem_addr, 16'h01C0);
      check("t2_second_wr",   mem_wr, 1'b1);
      do_burst(1'b1, 1'b1, 1'b1, 1'b0, 16'h01C0, 8);
      p1_req = 1'b0;
      gap_checks();

      // ---------------- continuous contention, 4 bursts ----------------
      do_reset();
      p0_req  = 1'b1;  p0_wr = 1'b0;  p0_addr = 16'h0100;
      p1_req  = 1'b1;  p1_wr = 1'b1;  p1_addr = 16'h0200;
      total_beats = 0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         #1;
         check("t3_gnt", gnt, (k % 2 == 1) ? 2'b10 : 2'b01);
         if (k % 2 == 1) do_burst(1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 8);
         else            do_burst(1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 8);
         gap_checks();
      end
      check("t3_total_beats", 64'(total_beats), 64'd32);
      p0_req = 1'b0;
      p1_req = 1'b0;

      // ---------------- reset mid-burst ----------------
      do_reset();
      p0_req  = 1'b1;  p0_wr = 1'b0;  p0_addr = 16'h0300;
      cyc();
      #1;
      check("t4_gnt", gnt, 2'b01);
      do_burst(1'b0, 1'b0, 1'b0, 1'b0, 16'h0300, 3);
      rst    = 1'b1;
      p0_req = 1'b0;
      cyc();
      #1;
      check("t4_rst_gnt",  gnt, 2'b00);
      check("t4_rst_req",  mem_req, 1'b0);
      check("t4_rst_done", burst_done, 1'b0);
      rst     = 1'b0;
      p1_req  = 1'b1;  p1_wr = 1'b0;  p1_addr = 16'h03C0;
      cyc();
      #1;
      check("t4_p1_gnt",  gnt, 2'b10);
      check("t4_p1_addr", mem_addr, 16'h03C0);
      // Owner drops req right after the grant; the burst must still run 8 beats.
      p1_req = 1'b0;
      do_burst(1'b1, 1'b0, 1'b0, 1'b0, 16'h03C0, 8);
      gap_checks();

      // ---------------- stray strobes ----------------
      do_reset();
      mem_rvalid = 1'b1;
      mem_ready  = 1'b1;
      #1;
      check("t5_idle_strb", {p0_ready, p0_rvalid, p1_ready, p1_rvalid}, 4'b0000);
      check("t5_idle_req",  mem_req, 1'b0);
      cyc();
      #1;
      check("t5_idle_strb2", {p0_ready, p0_rvalid, p1_ready, p1_rvalid}, 4'b0000);
      check("t5_idle_gnt",   gnt, 2'b00);
      mem_rvalid = 1'b0;
      mem_ready  = 1'b0;
      p0_req  = 1'b1;  p0_wr = 1'b0;  p0_addr = 16'h0400;
      cyc();
      #1;
      check("t5_gnt", gnt, 2'b01);
      p0_req = 1'b0;
      do_burst(1'b0, 1'b0, 1'b1, 1'b1, 16'h0400, 8);
      gap_checks();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
